// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - APB initiator turning single valid/ready commands into timer register transfers
module apb_cmd_master #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic                tim_pready,
  input  logic                tim_pslverr,
  input  logic [DATA_W-1:0]   tim_prdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_inc;
  logic        cmd_fire;
  logic        timeout_hit;

  assign cmd_fire     = cmd_valid & cmd_ready;
  assign wait_cnt_inc = wait_cnt + 16'd1;
  // Abort on the cycle whose unready edge would bring the count to the limit
  assign timeout_hit  = (TIMEOUT_LIM != 16'd0) && (wait_cnt_inc == TIMEOUT_LIM);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= 16'd0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      tim_psel    <= 1'b0;
      tim_penable <= 1'b0;
      tim_pwrite  <= 1'b0;
      tim_paddr   <= '0;
      tim_pwdata  <= '0;
      tim_pstrb   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_fire) begin
            cmd_ready  <= 1'b0;
            state      <= ST_SETUP;
            rsp_rdata  <= '0;
            tim_psel   <= 1'b1;
            tim_pwrite <= cmd_write;
            tim_paddr  <= cmd_addr;
            tim_pwdata <= cmd_write ? cmd_wdata : '0;
            tim_pstrb  <= cmd_write ? cmd_strb : '0;
          end
        end
        ST_SETUP: begin
          tim_penable <= 1'b1;
          wait_cnt    <= 16'd0;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A ready slave wins over a timeout landing in the same cycle
          if (tim_pready || timeout_hit) begin
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            tim_pwrite  <= 1'b0;
            tim_paddr   <= '0;
            tim_pwdata  <= '0;
            tim_pstrb   <= '0;
            if (tim_pready) begin
              rsp_rdata   <= tim_pwrite ? '0 : tim_prdata;
              rsp_err     <= tim_pslverr;
              rsp_timeout <= 1'b0;
            end else begin
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            cmd_ready   <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
